eaglesong_bit_matrix_seq: RTL and testbench

Sequential controller that runs the Eaglesong 16x16 bit-matrix mixing step. It does this by walking the eaglesong_bit_matrix lookup one bit index per cycle. The block latches a 512-bit state of sixteen 32-bit words and drives bit_index_to_request 0..255. For each index it conditionally XORs one input word into one output accumulator. It sits between the round sequencer and the combinational eaglesong_bit_matrix ROM, and it owns that ROM's index port exclusively.

---
 rtl/eaglesong_bit_matrix_seq.sv | 70 +++++++
 tb/tb_eaglesong_bit_matrix_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/eaglesong_bit_matrix_seq.sv
// eaglesong_bit_matrix_seq: 16x16 bit-matrix mix, walking the matrix ROM one bit index per cycle.
// Optional abort input when EAGLESONG_BM_ABORT_EN is defined.
module eaglesong_bit_matrix_seq #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 16,
  parameter int STATE_W = WORD_W * N_WORDS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [STATE_W-1:0]             state_in,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic [STATE_W-1:0]             state_out,
  output logic [2*$clog2(N_WORDS)-1:0]   bit_index_to_request,
`ifdef EAGLESONG_BM_ABORT_EN
  input  logic                           abort,
`endif
  input  logic                           requested_bit
);
  localparam int LOG_N = $clog2(N_WORDS);
  localparam int IDX_W = 2 * LOG_N;
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st;
  logic [IDX_W-1:0] idx;
  logic [LOG_N-1:0] row, col;
  logic [STATE_W-1:0] in_reg, acc, acc_nxt;
  logic [WORD_W-1:0] in_word;
  assign col = idx[LOG_N-1:0];
  assign row = idx[IDX_W-1:LOG_N];
  assign in_word = in_reg[WORD_W*col +: WORD_W];
  // matrix bit (row, col) folds input word col into accumulator word row
  assign acc_nxt = acc ^ (requested_bit ? (STATE_W'(in_word) << (WORD_W*row)) : '0);
  assign ready = st != RUN;
  assign busy = st == RUN;
  assign bit_index_to_request = busy ? idx : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      idx <= '0;
      acc <= '0;
      in_reg <= '0;
      state_out <= '0;
      done <= 1'b0;
    end else if (st != RUN) begin
      done <= 1'b0;
      if (start) begin
        st <= RUN;
        in_reg <= state_in;
        acc <= '0;
        idx <= '0;
      end
`ifdef EAGLESONG_BM_ABORT_EN
    end else if (abort) begin
      st <= IDLE;
      idx <= '0;
      acc <= '0;
`endif
    end else begin
      acc <= acc_nxt;
      idx <= idx + 1'b1;
      if (&idx) begin
        st <= DONE;
        state_out <= acc_nxt;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_eaglesong_bit_matrix_seq.sv
// tb_eaglesong_bit_matrix_seq: directed and random runs against a word-level matrix-product model.
module tb_eaglesong_bit_matrix_seq;
  localparam int SW = 512;
  logic clk = 1'b0;
  logic reset_n, start, ready, busy, done, requested_bit;
  logic [SW-1:0] state_in, state_out;
  logic [7:0] bit_index_to_request;
`ifdef EAGLESONG_BM_ABORT_EN
  logic abort;
`endif
  int checks = 0;
  int errors = 0;
  // m_row[j][k] is matrix bit M[16*j+k]
  logic [15:0] m_row [16] = '{16'h8FAF, 16'h9F5E, 16'hBEBC, 16'hFD78, 16'h7557, 16'h3A61,
                              16'hC3D2, 16'h1E87, 16'hA5F0, 16'h69B3, 16'hD20F, 16'h4CE5,
                              16'hF0A9, 16'h2B7D, 16'h87C6, 16'h5AC3};
  always #5 clk = ~clk;
  assign requested_bit = m_row[bit_index_to_request[7:4]][bit_index_to_request[3:0]];
  eaglesong_bit_matrix_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .state_in(state_in), .ready(ready),
    .busy(busy), .done(done), .state_out(state_out), .bit_index_to_request(bit_index_to_request),
`ifdef EAGLESONG_BM_ABORT_EN
    .abort(abort),
`endif
    .requested_bit(requested_bit));
  function automatic logic [SW-1:0] model(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        if (m_row[j][k]) r[32*j +: 32] = r[32*j +: 32] ^ s[32*k +: 32];
    return r;
  endfunction
  function automatic logic [SW-1:0] rnd_state();
    logic [SW-1:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic begin_run(input logic [SW-1:0] s);
    state_in = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic [SW-1:0] s, input int ign, input logic [SW-1:0] other);
    int c, n_busy, idx_err, so_err;
    logic [SW-1:0] prev;
    c = 0; n_busy = 0; idx_err = 0; so_err = 0;
    prev = state_out;
    while (!done && c < 300) begin
      if (busy) begin
        n_busy++;
        if (bit_index_to_request !== 8'(c)) idx_err++;
        if (state_out !== prev) so_err++;
      end
      if (c == ign) begin
        start = 1'b1;
        state_in = other;
      end else start = 1'b0;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"}, SW'(done), SW'(1));
    chk({tag, " busy_cycles"}, SW'(n_busy), SW'(256));
    chk({tag, " index_seq_errs"}, SW'(idx_err), '0);
    chk({tag, " out_stable_in_run"}, SW'(so_err), '0);
    chk({tag, " state_out"}, state_out, model(s));
    chk({tag, " idx_in_done"}, SW'(bit_index_to_request), '0);
    chk({tag, " ready_in_done"}, SW'(ready), SW'(1));
  endtask
  task automatic run(input string tag, input logic [SW-1:0] s);
    begin_run(s);
    wait_done(tag, s, -1, '0);
  endtask
  initial begin
    logic [SW-1:0] s, s2, prev;
    int n_done;
    reset_n = 1'b0;
    start = 1'b0;
    state_in = '0;
`ifdef EAGLESONG_BM_ABORT_EN
    abort = 1'b0;
`endif
    #3;
    chk("rst state_out", state_out, '0);
    chk("rst flags", SW'({ready, busy, done}), SW'(3'b100));
    chk("rst idx", SW'(bit_index_to_request), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    s = '0; s[31:0] = 32'hDEADBEEF;
    run("deadbeef", s);
    chk("deadbeef word0", SW'(state_out[31:0]), SW'(32'hDEADBEEF));
    @(negedge clk);
    chk("done_one_cycle", SW'(done), '0);
    chk("out_held", state_out, model(s));
    chk("ready_held", SW'({ready, busy}), SW'(2'b10));
    s = '0; s[64 +: 32] = 32'h12345678;
    run("word2", s);
    chk("word2 word0", SW'(state_out[31:0]), SW'(32'h12345678));
    @(negedge clk);
    s = '0; s[13*32 +: 32] = 32'hFFFFFFFF;
    run("word13", s);
    chk("word13 word15", SW'(state_out[15*32 +: 32]), '0);
    @(negedge clk);
    s = rnd_state();
    s2 = rnd_state();
    begin_run(s);
    wait_done("ignore_start", s, 100, s2);
    s2 = rnd_state();
    begin_run(s2);
    wait_done("back_to_back", s2, -1, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run("random", rnd_state());
    end
    @(negedge clk);
    begin_run(rnd_state());
    repeat (128) @(negedge clk);
    chk("midrun idx", SW'(bit_index_to_request), SW'(128));
    reset_n = 1'b0;
    #1;
    chk("midrun_rst flags", SW'({ready, busy, done}), SW'(3'b100));
    chk("midrun_rst state_out", state_out, '0);
    chk("midrun_rst idx", SW'(bit_index_to_request), '0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no_done_after_rst", SW'(n_done), '0);
    run("after_rst", rnd_state());
`ifdef EAGLESONG_BM_ABORT_EN
    @(negedge clk);
    prev = state_out;
    begin_run(rnd_state());
    repeat (50) @(negedge clk);
    chk("abort idx", SW'(bit_index_to_request), SW'(50));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort flags", SW'({ready, busy, done}), SW'(3'b100));
    chk("abort state_out", state_out, prev);
    n_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no_done_after_abort", SW'(n_done), '0);
    run("after_abort", rnd_state());
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
